spi_cfg_slave: RTL and testbench

- Responder (target) for the 3-wire 24-bit configuration frame the FPGA drives to the AD9518: nCS, SCLK, SDIO; mode 3 (SCLK idles high); data changes on the falling edge and is sampled on the rising edge; MSB first.
- Lets an external host (MCU or debug header) write and read the FPGA's local configuration register file with the same frame format.
- Oversamples the SPI pins in the CLK domain. Decodes a 16-bit instruction plus one data byte into single-cycle register-file write and read strobes.

---
 rtl/spi_cfg_pkg.sv | 37 +++
 rtl/spi_cfg_slave_if.sv | 35 +++
 rtl/spi_edge_sync.sv | 64 ++++++
 rtl/spi_cfg_slave.sv | 216 +++++++++++++++++++++
 tb/tb_spi_cfg_slave.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cfg_pkg
//  Description : Shared types and frame constants for the SPI configuration
//                slave: FSM state encoding, frame geometry, bit positions of
//                the R/nW and W1:W0 instruction fields, bit-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INSTR   = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RDATA   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5,
        ST_WAIT_CS = 3'd6
    } state_t;

    localparam int FRAME_BITS = 24;
    localparam int INSTR_BITS = 16;
    localparam int DATA_BITS  = 8;

    // Field positions within the full 24-bit frame.
    localparam int RNW_BIT = 23;
    localparam int W1_BIT  = 22;
    localparam int W0_BIT  = 21;

    localparam int BITCNT_W = 5;

    // Bit-counter values seen just before the 16th / 24th rising edge.
    localparam logic [BITCNT_W-1:0] INSTR_LAST = BITCNT_W'(INSTR_BITS - 1);
    localparam logic [BITCNT_W-1:0] FRAME_LAST = BITCNT_W'(FRAME_BITS - 1);

endpackage
`default_nettype wire

// File: rtl/spi_cfg_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cfg_slave_if
//  Description : Register-file access bus between the SPI configuration slave
//                (slave modport) and the local register file (master modport).
//  Ports       : WR_EN/WR_ADDR/WR_DATA  one-cycle write strobe with payload
//                RD_REQ/RD_ADDR         one-cycle read strobe with address
//                RD_DATA                combinational read data, valid with RD_REQ
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_cfg_slave_if
    import spi_cfg_pkg::*;
#(
    parameter int ADDR_W = 13
) ();

    logic                 WR_EN;
    logic [ADDR_W-1:0]    WR_ADDR;
    logic [DATA_BITS-1:0] WR_DATA;
    logic                 RD_REQ;
    logic [ADDR_W-1:0]    RD_ADDR;
    logic [DATA_BITS-1:0] RD_DATA;

    modport slave (
        output WR_EN, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR,
        input  RD_DATA
    );

    modport master (
        input  WR_EN, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR,
        output RD_DATA
    );

endinterface
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_sync
//  Description : Multi-stage synchronizers for nCS, SCLK and SDI followed by a
//                one-cycle edge detector on nCS and SCLK.
//  Ports       : CLK, RST              clock, synchronous active-high reset
//                ncs_i, sclk_i, sdi_i  asynchronous SPI pins
//                ncs_o                 synchronized nCS level
//                ncs_rise_o/fall_o     nCS edge pulses (one cycle)
//                sclk_rise_o/fall_o    SCLK edge pulses (one cycle)
//                sdi_o                 SDI aligned with the SCLK edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ncs_i,
    input  logic sclk_i,
    input  logic sdi_i,
    output logic ncs_o,
    output logic ncs_rise_o,
    output logic ncs_fall_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic sdi_o
);

    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   ncs_prev_q;
    logic                   sclk_prev_q;

    // nCS and SCLK preset to their idle level so that reset itself never
    // manufactures a rising edge on either line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '1;
            sdi_sync_q  <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
            ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ncs_o       = ncs_sync_q[SYNC_STAGES-1];
    assign ncs_rise_o  =  ncs_sync_q[SYNC_STAGES-1] & ~ncs_prev_q;
    assign ncs_fall_o  = ~ncs_sync_q[SYNC_STAGES-1] &  ncs_prev_q;
    assign sclk_rise_o =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
    // SDI travels through the same number of stages as SCLK, so this is the
    // value present on the pin when the SCLK edge was captured.
    assign sdi_o       = sdi_sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_cfg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cfg_slave
//  Description : 3-wire, mode-3, 24-bit SPI configuration target. Decodes a
//                16-bit instruction (R/nW, W1:W0, address) plus one data byte
//                into single-cycle register-file write/read strobes, and
//                serializes read data MSB-first on SDO.
//  Ports       : CLK, RST        clock, synchronous active-high reset
//                SPI_nCS/SCLK/SDI asynchronous SPI inputs
//                SPI_SDO/SDO_OE  serial read data and pad output enable
//                regs            register-file bus (slave modport)
//                FRAME_ERR       one-cycle pulse on a malformed frame
//                BUSY            high while not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cfg_slave
    import spi_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 13
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SPI_nCS,
    input  logic            SPI_SCLK,
    input  logic            SPI_SDI,
    output logic            SPI_SDO,
    output logic            SPI_SDO_OE,
    spi_cfg_slave_if.slave  regs,
    output logic            FRAME_ERR,
    output logic            BUSY
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SYNC_STAGES + 1);

    logic w_ncs, w_ncs_rise, w_ncs_fall, w_sclk_rise, w_sclk_fall, w_sdi;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK         (CLK),
        .RST         (RST),
        .ncs_i       (SPI_nCS),
        .sclk_i      (SPI_SCLK),
        .sdi_i       (SPI_SDI),
        .ncs_o       (w_ncs),
        .ncs_rise_o  (w_ncs_rise),
        .ncs_fall_o  (w_ncs_fall),
        .sclk_rise_o (w_sclk_rise),
        .sclk_fall_o (w_sclk_fall),
        .sdi_o       (w_sdi)
    );

    state_t                   state_q;
    logic [SETTLE_W-1:0]      settle_q;
    logic [BITCNT_W-1:0]      bitcnt_q;
    logic [INSTR_BITS-2:0]    shift_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_BITS-1:0]     tx_q;
    logic                     overrun_q;
    logic                     wr_en_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [DATA_BITS-1:0]     wr_data_q;
    logic                     rd_req_q;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic                     sdo_q;
    logic                     sdo_oe_q;
    logic                     frame_err_q;

    // Shift register contents including the bit sampled this cycle; the low
    // 16 bits are the instruction at bit 16 and the low 8 the data at bit 24.
    logic [INSTR_BITS-1:0] w_shift_nxt;
    logic                  w_in_frame;
    logic                  w_abort_err;

    assign w_shift_nxt = {shift_q, w_sdi};
    assign w_in_frame  = state_q inside {ST_INSTR, ST_WDATA, ST_RDATA, ST_DONE, ST_ERR};
    assign w_abort_err = ((state_q inside {ST_INSTR, ST_WDATA, ST_RDATA, ST_ERR}) &&
                          (bitcnt_q != '0)) ||
                         ((state_q == ST_DONE) && overrun_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            settle_q    <= SETTLE_INIT;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            overrun_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;

            // The synchronizers restart at the idle level after reset; an nCS
            // fall seen within this window is a frame that was already open
            // across reset, not a new one.
            if (settle_q != '0) begin
                settle_q <= settle_q - SETTLE_W'(1);
            end

            if (w_ncs_rise) begin
                // nCS rise takes priority over any SCLK edge in the same cycle.
                frame_err_q <= w_abort_err;
                state_q     <= ST_IDLE;
                sdo_q       <= 1'b0;
                sdo_oe_q    <= 1'b0;
                overrun_q   <= 1'b0;
            end else begin
                // Saturate so a runaway clock cannot wrap the count back to 0.
                if (w_in_frame && w_sclk_rise && (bitcnt_q != '1)) begin
                    bitcnt_q <= bitcnt_q + BITCNT_W'(1);
                end

                case (state_q)
                    ST_IDLE: begin
                        if (w_ncs_fall) begin
                            state_q  <= (settle_q != '0) ? ST_WAIT_CS : ST_INSTR;
                            bitcnt_q <= '0;
                        end
                    end

                    ST_INSTR: begin
                        if (w_sclk_rise) begin
                            shift_q <= w_shift_nxt[INSTR_BITS-2:0];
                            if (bitcnt_q == INSTR_LAST) begin
                                addr_q <= w_shift_nxt[ADDR_W-1:0];
                                if (w_shift_nxt[W1_BIT-DATA_BITS] || w_shift_nxt[W0_BIT-DATA_BITS]) begin
                                    state_q <= ST_ERR;
                                end else if (w_shift_nxt[RNW_BIT-DATA_BITS]) begin
                                    state_q   <= ST_RDATA;
                                    rd_req_q  <= 1'b1;
                                    rd_addr_q <= w_shift_nxt[ADDR_W-1:0];
                                    sdo_oe_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_WDATA;
                                end
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            shift_q <= w_shift_nxt[INSTR_BITS-2:0];
                            if (bitcnt_q == FRAME_LAST) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= w_shift_nxt[DATA_BITS-1:0];
                                state_q   <= ST_DONE;
                            end
                        end
                    end

                    ST_RDATA: begin
                        // RD_DATA is valid in the cycle RD_REQ is high; SCLK
                        // high time guarantees no falling edge in that cycle.
                        if (rd_req_q) begin
                            tx_q <= regs.RD_DATA;
                        end else if (w_sclk_fall) begin
                            sdo_q <= tx_q[DATA_BITS-1];
                            tx_q  <= {tx_q[DATA_BITS-2:0], 1'b0};
                        end
                        if (w_sclk_rise && (bitcnt_q == FRAME_LAST)) begin
                            state_q <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        if (w_sclk_rise) begin
                            overrun_q <= 1'b1;
                        end
                        if (w_sclk_fall) begin
                            sdo_q <= 1'b0;
                        end
                    end

                    ST_ERR: begin
                        // Bits are counted but otherwise ignored.
                    end

                    ST_WAIT_CS: begin
                        if (w_ncs) begin
                            state_q <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign regs.WR_EN   = wr_en_q;
    assign regs.WR_ADDR = wr_addr_q;
    assign regs.WR_DATA = wr_data_q;
    assign regs.RD_REQ  = rd_req_q;
    assign regs.RD_ADDR = rd_addr_q;
    assign SPI_SDO      = sdo_q;
    assign SPI_SDO_OE   = sdo_oe_q;
    assign FRAME_ERR    = frame_err_q;
    assign BUSY         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_cfg_slave
//  Description : Self-checking bench for spi_cfg_slave: directed frame table,
//                latency and reset-mid-frame sequences, random frames checked
//                against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_slave;

    localparam int ADDR_W = 13;

    typedef struct packed {
        logic [7:0]        wr_cnt;
        logic [ADDR_W-1:0] wr_addr;
        logic [7:0]        wr_data;
        logic [7:0]        rd_cnt;
        logic [ADDR_W-1:0] rd_addr;
        logic [7:0]        err_cnt;
        logic [7:0]        sdo;
        logic              oe;
    } exp_t;

    typedef struct {
        logic [23:0] frame;
        int          nbits;
        logic [7:0]  rdd;
        bit          lat;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ncs = 1'b1;
    logic sclk = 1'b1;
    logic sdi = 1'b0;
    logic sdo, sdo_oe, frame_err, busy;
    logic [7:0] rd_data_v = 8'h00;

    spi_cfg_slave_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.RD_DATA = rd_data_v;

    spi_cfg_slave #(
        .SYNC_STAGES (2),
        .ADDR_W      (ADDR_W)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .SPI_nCS    (ncs),
        .SPI_SCLK   (sclk),
        .SPI_SDI    (sdi),
        .SPI_SDO    (sdo),
        .SPI_SDO_OE (sdo_oe),
        .regs       (bus.slave),
        .FRAME_ERR  (frame_err),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Event monitor: cumulative counts of strobe cycles on the falling edge.
    int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_err_busy = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [7:0]        last_wr_data = '0;

    always @(negedge clk) begin
        if (bus.WR_EN) begin
            n_wr = n_wr + 1;
            last_wr_addr = bus.WR_ADDR;
            last_wr_data = bus.WR_DATA;
        end
        if (bus.RD_REQ) begin
            n_rd = n_rd + 1;
            last_rd_addr = bus.RD_ADDR;
        end
        if (frame_err) begin
            n_err = n_err + 1;
            if (busy) n_err_busy = n_err_busy + 1;
        end
        if (sdo_oe) n_oe = n_oe + 1;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int wc, input int wa, input int wd, input int rc,
                                input int ra, input int ec, input int sd, input int oe);
        exp_t e;
        e.wr_cnt  = 8'(wc);
        e.wr_addr = ADDR_W'(wa);
        e.wr_data = 8'(wd);
        e.rd_cnt  = 8'(rc);
        e.rd_addr = ADDR_W'(ra);
        e.err_cnt = 8'(ec);
        e.sdo     = 8'(sd);
        e.oe      = 1'(oe);
        return e;
    endfunction

    // Frame-level reference: outcome of a frame of n bits from the frame rules.
    function automatic exp_t model(input logic [23:0] f, input int n, input logic [7:0] rdd);
        exp_t e;
        int   nb;
        e  = '0;
        nb = (n > 24) ? 24 : n;
        if (n == 0) return e;
        if (f[22:21] != 2'b00) begin
            e.err_cnt = 8'd1;
            return e;
        end
        e.err_cnt = (n != 24) ? 8'd1 : 8'd0;
        if (!f[23] && n >= 24) begin
            e.wr_cnt  = 8'd1;
            e.wr_addr = f[20:8];
            e.wr_data = f[7:0];
        end
        if (f[23] && n >= 16) begin
            e.rd_cnt  = 8'd1;
            e.rd_addr = f[20:8];
            e.oe      = 1'b1;
            e.sdo     = 8'(rdd >> (8 - (nb - 16)));
        end
        return e;
    endfunction

    logic [7:0] sdo_cap = 8'h00;

    task automatic cs_low();
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode 3: data changes on the falling edge, host samples SDO just before
    // raising SCLK; half period is 4 CLK cycles.
    task automatic send_bits(input logic [23:0] f, input int first, input int last, input bit lat);
        logic [3:0] seen;
        for (int i = first; i < last; i++) begin
            sclk = 1'b0;
            sdi  = (i < 24) ? f[23-i] : 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            if (i >= 16 && i < 24) sdo_cap = {sdo_cap[6:0], sdo};
            sclk = 1'b1;
            if (lat && i == 23) begin
                seen = '0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    seen[j] = bus.WR_EN;
                end
                // Two sync stages + edge detect + registered strobe.
                chk("wr_en_latency", 32'(seen), 32'h4);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input logic [23:0] f, input int n, input logic [7:0] rdd,
                             input bit lat, output exp_t got);
        int w0, r0, e0, o0;
        rd_data_v = rdd;
        sdo_cap   = 8'h00;
        w0 = n_wr; r0 = n_rd; e0 = n_err; o0 = n_oe;
        cs_low();
        send_bits(f, 0, n, lat);
        cs_high();
        got         = '0;
        got.wr_cnt  = 8'(n_wr - w0);
        got.wr_addr = last_wr_addr;
        got.wr_data = last_wr_data;
        got.rd_cnt  = 8'(n_rd - r0);
        got.rd_addr = last_rd_addr;
        got.err_cnt = 8'(n_err - e0);
        got.sdo     = sdo_cap;
        got.oe      = (n_oe != o0);
    endtask

    task automatic cmp(input string nm, input exp_t g, input exp_t e);
        chk({nm, ".wr_cnt"},  32'(g.wr_cnt),  32'(e.wr_cnt));
        chk({nm, ".rd_cnt"},  32'(g.rd_cnt),  32'(e.rd_cnt));
        chk({nm, ".err_cnt"}, 32'(g.err_cnt), 32'(e.err_cnt));
        chk({nm, ".sdo"},     32'(g.sdo),     32'(e.sdo));
        chk({nm, ".oe_seen"}, 32'(g.oe),      32'(e.oe));
        if (e.wr_cnt != 0) begin
            chk({nm, ".wr_addr"}, 32'(g.wr_addr), 32'(e.wr_addr));
            chk({nm, ".wr_data"}, 32'(g.wr_data), 32'(e.wr_data));
        end
        if (e.rd_cnt != 0) begin
            chk({nm, ".rd_addr"}, 32'(g.rd_addr), 32'(e.rd_addr));
        end
        chk({nm, ".busy_after"},   32'(busy),   32'd0);
        chk({nm, ".oe_after"},     32'(sdo_oe), 32'd0);
        chk({nm, ".sdo_idle"},     32'(sdo),    32'd0);
    endtask

    vec_t        tbl[9];
    exp_t        got, e;
    logic [23:0] rf;
    int          rn;
    logic [7:0]  rdd;
    int          w0, r0, e0;

    initial begin
        tbl[0] = '{24'h0010A5, 24, 8'h00, 1'b1, mk(1, 'h010, 'hA5, 0, 0,      0, 0,    0)};
        tbl[1] = '{24'h800300, 24, 8'h5C, 1'b0, mk(0, 0,     0,    1, 'h003,  0, 'h5C, 1)};
        tbl[2] = '{24'h0010A5, 10, 8'h00, 1'b0, mk(0, 0,     0,    0, 0,      1, 0,    0)};
        tbl[3] = '{24'h0020FF, 24, 8'h00, 1'b0, mk(1, 'h020, 'hFF, 0, 0,      0, 0,    0)};
        tbl[4] = '{24'h204000, 24, 8'h00, 1'b0, mk(0, 0,     0,    0, 0,      1, 0,    0)};
        tbl[5] = '{24'h001133, 26, 8'h00, 1'b0, mk(1, 'h011, 'h33, 0, 0,      1, 0,    0)};
        tbl[6] = '{24'h000000, 0,  8'h00, 1'b0, mk(0, 0,     0,    0, 0,      0, 0,    0)};
        tbl[7] = '{24'h8ABC00, 20, 8'h96, 1'b0, mk(0, 0,     0,    1, 'h0ABC, 1, 'h09, 1)};
        tbl[8] = '{24'h800300, 16, 8'hFF, 1'b0, mk(0, 0,     0,    1, 'h003,  1, 0,    1)};

        // Reset state.
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst.wr_en",   32'(bus.WR_EN),   32'd0);
        chk("rst.wr_addr", 32'(bus.WR_ADDR), 32'd0);
        chk("rst.wr_data", 32'(bus.WR_DATA), 32'd0);
        chk("rst.rd_req",  32'(bus.RD_REQ),  32'd0);
        chk("rst.rd_addr", 32'(bus.RD_ADDR), 32'd0);
        chk("rst.sdo",     32'(sdo),         32'd0);
        chk("rst.sdo_oe",  32'(sdo_oe),      32'd0);
        chk("rst.ferr",    32'(frame_err),   32'd0);
        chk("rst.busy",    32'(busy),        32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst.busy", 32'(busy), 32'd0);

        // Directed frame table.
        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].frame, tbl[i].nbits, tbl[i].rdd, tbl[i].lat, got);
            cmp($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Reset pulse after 12 bits with nCS held low, rest of frame sent.
        w0 = n_wr; r0 = n_rd; e0 = n_err;
        cs_low();
        send_bits(24'h0010A5, 0, 12, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid.busy_wait_cs", 32'(busy), 32'd1);
        send_bits(24'h0010A5, 12, 24, 1'b0);
        cs_high();
        chk("rstmid.wr_cnt",  32'(n_wr - w0),  32'd0);
        chk("rstmid.rd_cnt",  32'(n_rd - r0),  32'd0);
        chk("rstmid.err_cnt", 32'(n_err - e0), 32'd0);
        chk("rstmid.busy",    32'(busy),       32'd0);
        run_frame(24'h000142, 24, 8'h00, 1'b0, got);
        cmp("rstmid_next", got, mk(1, 'h001, 'h42, 0, 0, 0, 0, 0));

        // Random frames against the frame-level model.
        for (int t = 0; t < 40; t++) begin
            rf = 24'($urandom);
            if ($urandom_range(0, 3) != 0) rf[22:21] = 2'b00;
            rn  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 27)) : 24;
            rdd = 8'($urandom);
            e   = model(rf, rn, rdd);
            run_frame(rf, rn, rdd, 1'b0, got);
            cmp($sformatf("rnd%0d_f%06h_n%0d", t, rf, rn), got, e);
        end

        chk("ferr_while_busy", 32'(n_err_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
